// File: rtl/memory_arbiter.sv
// Two-requester round-robin arbiter in front of a shared single-port memory
// with combinational read data. Each requester has a one-entry response slot.
module memory_arbiter #(
  parameter int address_width = 32,
  parameter int word_width    = 32
) (
  input  logic                     clock,
  input  logic                     reset,

  input  logic                     request_valid_0,
  input  logic                     request_write_0,
  input  logic [address_width-1:0] request_address_0,
  input  logic [word_width-1:0]    request_data_0,
  output logic                     request_ready_0,
  output logic                     response_valid_0,
  output logic [word_width-1:0]    response_data_0,
  input  logic                     response_ready_0,

  input  logic                     request_valid_1,
  input  logic                     request_write_1,
  input  logic [address_width-1:0] request_address_1,
  input  logic [word_width-1:0]    request_data_1,
  output logic                     request_ready_1,
  output logic                     response_valid_1,
  output logic [word_width-1:0]    response_data_1,
  input  logic                     response_ready_1,

  output logic                     memory_write_enable,
  output logic [address_width-1:0] memory_address,
  output logic [word_width-1:0]    memory_write_data,
  input  logic [word_width-1:0]    memory_read_data
);

  logic [1:0]               req_valid;
  logic [1:0]               req_write;
  logic [1:0]               resp_ready;
  logic [address_width-1:0] req_addr [2];
  logic [word_width-1:0]    req_data [2];

  logic [1:0]               eligible;
  logic [1:0]               grant;
  logic                     grant_sel;

  logic                     last_grant_q, last_grant_d;
  logic [1:0]               resp_valid_q, resp_valid_d;
  logic [word_width-1:0]    resp_data_q [2];
  logic [word_width-1:0]    resp_data_d [2];

  assign req_valid   = {request_valid_1, request_valid_0};
  assign req_write   = {request_write_1, request_write_0};
  assign resp_ready  = {response_ready_1, response_ready_0};
  assign req_addr[0] = request_address_0;
  assign req_addr[1] = request_address_1;
  assign req_data[0] = request_data_0;
  assign req_data[1] = request_data_1;

  // A requester may only be granted when its response slot is free or is
  // being drained in this very cycle.
  for (genvar gi = 0; gi < 2; gi++) begin : g_eligible
    assign eligible[gi] = ~reset & req_valid[gi] &
                          (~resp_valid_q[gi] | resp_ready[gi]);
  end

  always_comb begin
    grant        = eligible;
    last_grant_d = last_grant_q;
    if (eligible == 2'b11) begin
      grant = last_grant_q ? 2'b01 : 2'b10;
    end
    if (grant[0]) begin
      last_grant_d = 1'b0;
    end else if (grant[1]) begin
      last_grant_d = 1'b1;
    end
  end

  // With no grant the mux falls back to requester 0.
  assign grant_sel           = grant[1];
  assign memory_address      = req_addr[grant_sel];
  assign memory_write_data   = req_data[grant_sel];
  assign memory_write_enable = (|grant) & req_write[grant_sel];

  always_comb begin
    for (int n = 0; n < 2; n++) begin
      resp_valid_d[n] = resp_valid_q[n] & ~resp_ready[n];
      resp_data_d[n]  = resp_data_q[n];
      if (grant[n] && !req_write[n]) begin
        resp_valid_d[n] = 1'b1;
        resp_data_d[n]  = memory_read_data;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant_q <= 1'b1;
      resp_valid_q <= 2'b00;
      for (int n = 0; n < 2; n++) begin
        resp_data_q[n] <= '0;
      end
    end else begin
      last_grant_q <= last_grant_d;
      resp_valid_q <= resp_valid_d;
      for (int n = 0; n < 2; n++) begin
        resp_data_q[n] <= resp_data_d[n];
      end
    end
  end

  assign request_ready_0  = grant[0];
  assign request_ready_1  = grant[1];
  // Responses are hidden while reset is held, even one captured just before.
  assign response_valid_0 = resp_valid_q[0] & ~reset;
  assign response_valid_1 = resp_valid_q[1] & ~reset;
  assign response_data_0  = resp_data_q[0];
  assign response_data_1  = resp_data_q[1];

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed vector table, hand-written corner
// sequences and random traffic, all checked against a behavioural model.
module tb_memory_arbiter;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic        init_mem;
  logic [1:0]  v, w, rr;
  logic [31:0] a [2];
  logic [31:0] d [2];
  logic        rdy0, rdy1, rv0, rv1, we;
  logic [31:0] rd0, rd1, maddr, mwd, mrd;

  memory_arbiter #(.address_width(32), .word_width(32)) dut (
    .clock(clock), .reset(reset),
    .request_valid_0(v[0]), .request_write_0(w[0]),
    .request_address_0(a[0]), .request_data_0(d[0]),
    .request_ready_0(rdy0), .response_valid_0(rv0),
    .response_data_0(rd0), .response_ready_0(rr[0]),
    .request_valid_1(v[1]), .request_write_1(w[1]),
    .request_address_1(a[1]), .request_data_1(d[1]),
    .request_ready_1(rdy1), .response_valid_1(rv1),
    .response_data_1(rd1), .response_ready_1(rr[1]),
    .memory_write_enable(we), .memory_address(maddr),
    .memory_write_data(mwd), .memory_read_data(mrd)
  );

  // Shared memory: 64 words, combinational read, write at the clock edge.
  logic [31:0] mem [64];
  assign mrd = mem[maddr[7:2]];
  always @(posedge clock) begin
    if (init_mem) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'hA500_0000 | 32'(i);
    end else if (we) begin
      mem[maddr[7:2]] <= mwd;
    end
  end

  // Behavioural model state
  int          lg;
  logic [1:0]  pend;
  logic [31:0] pdata [2];
  logic [31:0] ref_mem [64];

  int nvec = 0;
  int nfail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock cycle: drive at negedge, compare before the next posedge,
  // then advance the model by the rules of one accepting edge.
  task automatic apply(input logic r, input logic [1:0] vv, input logic [1:0] ww,
                       input logic [1:0] rrr, input logic [31:0] a0, input logic [31:0] d0,
                       input logic [31:0] a1, input logic [31:0] d1);
    logic [1:0] elig;
    int g;
    @(negedge clock);
    reset = r; v = vv; w = ww; rr = rrr;
    a[0] = a0; d[0] = d0; a[1] = a1; d[1] = d1;
    #2;
    for (int n = 0; n < 2; n++)
      elig[n] = !r && vv[n] && (!pend[n] || rrr[n]);
    g = -1;
    if (elig == 2'b11) g = (lg == 0) ? 1 : 0;
    else if (elig[0]) g = 0;
    else if (elig[1]) g = 1;
    chk("ready0", rdy0, g == 0);
    chk("ready1", rdy1, g == 1);
    chk("mem_we", we, (g >= 0) && ww[(g >= 0) ? g : 0]);
    chk("mem_addr", maddr, (g == 1) ? a1 : a0);
    chk("mem_wdata", mwd, (g == 1) ? d1 : d0);
    chk("resp_valid0", rv0, pend[0] && !r);
    chk("resp_valid1", rv1, pend[1] && !r);
    chk("resp_data0", rd0, pdata[0]);
    chk("resp_data1", rd1, pdata[1]);
    if (r) begin
      lg = 1; pend = 2'b00; pdata[0] = '0; pdata[1] = '0;
    end else begin
      for (int n = 0; n < 2; n++)
        if (pend[n] && rrr[n]) pend[n] = 1'b0;
      if (g >= 0) begin
        if (ww[g]) ref_mem[a[g][7:2]] = d[g];
        else begin
          pend[g] = 1'b1;
          pdata[g] = ref_mem[a[g][7:2]];
        end
        lg = g;
      end
    end
  endtask

  typedef struct {
    logic        rst;
    logic [1:0]  v, w, rr;
    logic [31:0] a0, d0, a1, d1;
    logic [1:0]  e_rdy;
    logic        e_we;
    logic [1:0]  e_rv;
    logic [31:0] e_rd0, e_rd1;
  } vec_t;

  vec_t tbl [14];

  initial begin
    int g0, g1, c0, c1;
    logic prev;

    tbl[0]  = '{1'b1, 2'b11, 2'b00, 2'b00, 32'h10, 32'h0, 32'h10, 32'h0, 2'b00, 1'b0, 2'b00, 32'h0, 32'h0};
    tbl[1]  = '{1'b0, 2'b01, 2'b01, 2'b00, 32'h08, 32'hDEADBEEF, 32'h0, 32'h0, 2'b01, 1'b1, 2'b00, 32'h0, 32'h0};
    tbl[2]  = '{1'b0, 2'b01, 2'b00, 2'b00, 32'h08, 32'h0, 32'h0, 32'h0, 2'b01, 1'b0, 2'b00, 32'h0, 32'h0};
    tbl[3]  = '{1'b0, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 1'b0, 2'b01, 32'hDEADBEEF, 32'h0};
    tbl[4]  = '{1'b0, 2'b00, 2'b00, 2'b01, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 1'b0, 2'b01, 32'hDEADBEEF, 32'h0};
    tbl[5]  = '{1'b0, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 1'b0, 2'b00, 32'hDEADBEEF, 32'h0};
    tbl[6]  = '{1'b1, 2'b11, 2'b00, 2'b11, 32'h10, 32'h0, 32'h10, 32'h0, 2'b00, 1'b0, 2'b00, 32'hDEADBEEF, 32'h0};
    tbl[7]  = '{1'b0, 2'b11, 2'b00, 2'b11, 32'h10, 32'h0, 32'h10, 32'h0, 2'b01, 1'b0, 2'b00, 32'h0, 32'h0};
    tbl[8]  = '{1'b0, 2'b10, 2'b00, 2'b11, 32'h10, 32'h0, 32'h10, 32'h0, 2'b10, 1'b0, 2'b01, 32'hA5000004, 32'h0};
    tbl[9]  = '{1'b0, 2'b00, 2'b00, 2'b11, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 1'b0, 2'b10, 32'hA5000004, 32'hA5000004};
    tbl[10] = '{1'b0, 2'b11, 2'b10, 2'b11, 32'h10, 32'h0, 32'h10, 32'h12345678, 2'b01, 1'b0, 2'b00, 32'hA5000004, 32'hA5000004};
    tbl[11] = '{1'b0, 2'b10, 2'b10, 2'b11, 32'h10, 32'h0, 32'h10, 32'h12345678, 2'b10, 1'b1, 2'b01, 32'hA5000004, 32'hA5000004};
    tbl[12] = '{1'b0, 2'b01, 2'b00, 2'b11, 32'h10, 32'h0, 32'h0, 32'h0, 2'b01, 1'b0, 2'b00, 32'hA5000004, 32'hA5000004};
    tbl[13] = '{1'b0, 2'b00, 2'b00, 2'b11, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 1'b0, 2'b01, 32'h12345678, 32'hA5000004};

    reset = 1'b1; init_mem = 1'b1;
    v = '0; w = '0; rr = '0;
    a[0] = '0; a[1] = '0; d[0] = '0; d[1] = '0;
    lg = 1; pend = 2'b00; pdata[0] = '0; pdata[1] = '0;
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'hA500_0000 | 32'(i);
    repeat (2) @(posedge clock);
    @(negedge clock);
    init_mem = 1'b0;

    // Directed table
    for (int i = 0; i < 14; i++) begin
      apply(tbl[i].rst, tbl[i].v, tbl[i].w, tbl[i].rr,
            tbl[i].a0, tbl[i].d0, tbl[i].a1, tbl[i].d1);
      chk($sformatf("tbl%0d_ready", i), {rdy1, rdy0}, tbl[i].e_rdy);
      chk($sformatf("tbl%0d_we", i), we, tbl[i].e_we);
      chk($sformatf("tbl%0d_rvalid", i), {rv1, rv0}, tbl[i].e_rv);
      chk($sformatf("tbl%0d_rdata0", i), rd0, tbl[i].e_rd0);
      chk($sformatf("tbl%0d_rdata1", i), rd1, tbl[i].e_rd1);
    end

    // Continuous reads from both sides: grants alternate, 4 responses each
    g0 = 0; g1 = 0; c0 = 0; c1 = 0; prev = 1'b0;
    for (int k = 0; k < 8; k++) begin
      apply(1'b0, 2'b11, 2'b00, 2'b11, 32'(k) << 2, 32'h0, 32'(k + 8) << 2, 32'h0);
      if (rdy0) g0++;
      if (rdy1) g1++;
      if (rv0) c0++;
      if (rv1) c1++;
      if (k > 0) chk("alternate", rdy0, !prev);
      prev = rdy0;
    end
    apply(1'b0, 2'b00, 2'b00, 2'b11, 32'h0, 32'h0, 32'h0, 32'h0);
    if (rv0) c0++;
    if (rv1) c1++;
    chk("rr_grants0", g0, 4);
    chk("rr_grants1", g1, 4);
    chk("rr_resp0", c0, 4);
    chk("rr_resp1", c1, 4);

    // Requester 1 stalls its response; requester 0 keeps being served
    apply(1'b0, 2'b10, 2'b00, 2'b01, 32'h0, 32'h0, 32'h20, 32'h0);
    for (int k = 0; k < 5; k++) begin
      apply(1'b0, 2'b11, 2'b00, 2'b01, 32'h04, 32'h0, 32'h24, 32'h0);
      chk("stall_ready", {rdy1, rdy0}, 2'b01);
      chk("stall_rvalid1", rv1, 1'b1);
      chk("stall_rdata1", rd1, 32'hA5000008);
    end
    apply(1'b0, 2'b11, 2'b00, 2'b11, 32'h04, 32'h0, 32'h24, 32'h0);
    chk("unstall_ready", {rdy1, rdy0}, 2'b10);

    // Reset right after a read grant
    apply(1'b0, 2'b01, 2'b00, 2'b11, 32'h10, 32'h0, 32'h0, 32'h0);
    for (int k = 0; k < 2; k++) begin
      apply(1'b1, 2'b11, 2'b00, 2'b00, 32'h10, 32'h0, 32'h10, 32'h0);
      chk("rst_ready", {rdy1, rdy0}, 2'b00);
      chk("rst_rvalid", {rv1, rv0}, 2'b00);
    end
    apply(1'b0, 2'b11, 2'b00, 2'b11, 32'h10, 32'h0, 32'h10, 32'h0);
    chk("post_rst_tie", {rdy1, rdy0}, 2'b01);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic       r;
      logic [1:0] vv, ww, rrr;
      r   = ($urandom_range(0, 63) == 0);
      vv  = {($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7)};
      ww  = {($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 3)};
      rrr = {($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 6)};
      apply(r, vv, ww, rrr,
            32'($urandom_range(0, 15)) << 2, $urandom,
            32'($urandom_range(0, 15)) << 2, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter address_width, default 32: width of requester and memory addresses.
REQ-002 Parameter word_width, default 32: width of all data buses.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 request_valid_0 / request_valid_1  input  1  requester n presents an access.
REQ-006 request_write_0 / request_write_1  input  1  1 = write, 0 = read.
REQ-007 request_address_0 / request_address_1  input  address_width  byte address, passed through unmodified.
REQ-008 request_data_0 / request_data_1  input  word_width  write data.
REQ-009 request_ready_0 / request_ready_1  output  1  grant; the access is accepted at the rising edge where valid and ready are both 1.
REQ-010 response_valid_0 / response_valid_1  output  1  read data available.
REQ-011 response_data_0 / response_data_1  output  word_width  registered read data.
REQ-012 response_ready_0 / response_ready_1  input  1  requester consumes the response.
REQ-013 memory_write_enable  output  1  write strobe to the shared single-port memory.
REQ-014 memory_address  output  address_width  shared memory address.
REQ-015 memory_write_data  output  word_width  shared memory write data.
REQ-016 memory_read_data  input  word_width  combinational (same-cycle) read data from the memory.

Function
REQ-017 At most one requester SHALL be granted per cycle; request_ready_0 and request_ready_1 are never both 1.
REQ-018 Requester n SHALL be eligible only when request_valid_n=1 and its response slot is empty (response_valid_n=0, or response_valid_n=1 with response_ready_n=1 in the same cycle).
REQ-019 When one requester is eligible, it SHALL be granted. When both are eligible, the requester that is not last_grant SHALL be granted (round-robin).
REQ-020 last_grant SHALL update to the granted index on every grant and hold otherwise.
REQ-021 Grant is combinational: request_ready_n SHALL depend only on the current inputs and registered state, with no dependency on request_write or request_address.
REQ-022 With a grant active, memory_address and memory_write_data SHALL mux from the granted requester, and memory_write_enable SHALL equal the granted request_write. The memory commits the write at the same rising edge.
REQ-023 With no grant, memory_write_enable SHALL be 0, and memory_address and memory_write_data SHALL hold requester 0's values (don't-care for the memory).
REQ-024 For a granted read, memory_read_data SHALL be captured into response_data_n at the accepting edge, and response_valid_n SHALL be set: 1-cycle latency.
REQ-025 A granted write SHALL produce no response.
REQ-026 response_valid_n SHALL stay 1, with response_data_n held stable, until the edge where response_ready_n=1. It then clears, unless a new read is accepted at that same edge, in which case it stays 1 with the new data.
REQ-027 Each requester SHALL have at most one outstanding response. A stalled requester SHALL NOT block the other requester.
REQ-028 A read and a write to the same address in consecutive cycles SHALL observe program order. A read granted the cycle after a write returns the written data.
REQ-029 request_valid_n may drop without a grant. No state SHALL change for that requester.

Reset
REQ-030 While reset=1 at a rising edge: last_grant SHALL be set to 1, so that requester 0 wins the first tie. response_valid_0, response_valid_1 and both response_data registers SHALL be cleared to 0.
REQ-031 During any cycle with reset=1, request_ready_0, request_ready_1 and memory_write_enable SHALL be 0. Accesses and responses in flight are discarded.
REQ-032 The first grant SHALL be possible in the first cycle with reset=0.

Verification
REQ-033 After reset, both requesters read 0x10 in the same cycle -> requester 0 is granted that cycle, response_valid_0=1 the next cycle; requester 1 is granted the next cycle, response_valid_1=1 one cycle later.
REQ-034 Requester 0 writes 0xDEADBEEF to 0x08, then reads 0x08 the next cycle -> response_data_0=0xDEADBEEF with response_valid_0=1 one cycle after the read grant.
REQ-035 Both requesters hold valid reads continuously with response_ready=1 -> grants alternate 0,1,0,1 for 8 cycles; each requester receives 4 responses.
REQ-036 Requester 1 has a read response pending with response_ready_1=0 for 5 cycles, and both requesters keep requesting -> requester 0 is granted every cycle, request_ready_1=0, response_data_1 is stable; after response_ready_1=1, requester 1 is granted in that same cycle.
REQ-037 reset is asserted the cycle after a read grant -> response_valid_n=0 and request_ready=0 in every reset cycle; the first post-reset tie is granted to requester 0.
